// File: rtl/video_driver.sv
// video_driver: raster timing generator that requests pixels one clock ahead
// and emits registered hsync/vsync/de/rgb aligned with the returned pixel data.
module video_driver #(
    parameter logic [10:0] H_SYNC  = 11'd40,
    parameter logic [10:0] H_BACK  = 11'd220,
    parameter logic [10:0] H_DISP  = 11'd1280,
    parameter logic [10:0] H_FRONT = 11'd110,
    parameter logic [10:0] H_TOTAL = 11'd1650,
    parameter logic [10:0] V_SYNC  = 11'd5,
    parameter logic [10:0] V_BACK  = 11'd20,
    parameter logic [10:0] V_DISP  = 11'd720,
    parameter logic [10:0] V_FRONT = 11'd5,
    parameter logic [10:0] V_TOTAL = 11'd750,
    parameter logic        HS_POL  = 1'b1,
    parameter logic        VS_POL  = 1'b1
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic [23:0] pixel_data,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        data_req,
    output logic        video_hs,
    output logic        video_vs,
    output logic        video_de,
    output logic [23:0] video_rgb
);
    localparam logic [10:0] HA = H_SYNC + H_BACK;
    localparam logic [10:0] VA = V_SYNC + V_BACK;
    logic [10:0] r_cnt_h, r_cnt_v;
    logic        w_h_end, w_v_act, w_h_act, w_active;
    assign w_h_end  = r_cnt_h == H_TOTAL - 11'd1;
    assign w_v_act  = (r_cnt_v >= VA) && (r_cnt_v < VA + V_DISP);
    assign w_h_act  = (r_cnt_h >= HA) && (r_cnt_h < HA + H_DISP);
    assign w_active = w_h_act && w_v_act;
    // Request window is the active window shifted one clock earlier
    assign data_req   = (r_cnt_h >= HA - 11'd1) && (r_cnt_h < HA + H_DISP - 11'd1) && w_v_act;
    assign pixel_xpos = data_req ? r_cnt_h - (HA - 11'd1) : 11'd0;
    assign pixel_ypos = data_req ? r_cnt_v - VA : 11'd0;
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            r_cnt_h <= '0;
            r_cnt_v <= '0;
        end else begin
            r_cnt_h <= w_h_end ? 11'd0 : r_cnt_h + 11'd1;
            if (w_h_end)
                r_cnt_v <= (r_cnt_v == V_TOTAL - 11'd1) ? 11'd0 : r_cnt_v + 11'd1;
        end
    end
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            video_hs  <= ~HS_POL;
            video_vs  <= ~VS_POL;
            video_de  <= 1'b0;
            video_rgb <= '0;
        end else begin
            video_hs  <= (r_cnt_h < H_SYNC) ? HS_POL : ~HS_POL;
            video_vs  <= (r_cnt_v < V_SYNC) ? VS_POL : ~VS_POL;
            video_de  <= w_active;
            video_rgb <= w_active ? pixel_data : 24'd0;
        end
    end
endmodule

// File: tb/tb_video_driver.sv
// tb_video_driver: directed vectors on a shrunken raster plus line-level checks
// on the default 1280x720 timing.
module tb_video_driver;
    logic        clk = 1'b0, rst = 1'b1, rst_d = 1'b1;
    logic [23:0] pd, rgb, rgb_d;
    logic [10:0] x, y, x_d, y_d;
    logic        req, hs, vs, de, req_d, hs_d, vs_d, de_d;
    int          n_vec = 0, n_bad = 0, cyc = 0;
    always #5 clk = ~clk;
    // Small raster: HA=10, VA=5, 23 clocks/line, 11 lines/frame
    video_driver #(
        .H_SYNC(11'd4), .H_BACK(11'd6), .H_DISP(11'd10), .H_FRONT(11'd3), .H_TOTAL(11'd23),
        .V_SYNC(11'd2), .V_BACK(11'd3), .V_DISP(11'd4), .V_FRONT(11'd2), .V_TOTAL(11'd11),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_dut (
        .pixel_clk(clk), .rst(rst), .pixel_data(pd), .pixel_xpos(x), .pixel_ypos(y),
        .data_req(req), .video_hs(hs), .video_vs(vs), .video_de(de), .video_rgb(rgb)
    );
    video_driver u_def (
        .pixel_clk(clk), .rst(rst_d), .pixel_data(24'h5A5A5A), .pixel_xpos(x_d), .pixel_ypos(y_d),
        .data_req(req_d), .video_hs(hs_d), .video_vs(vs_d), .video_de(de_d), .video_rgb(rgb_d)
    );
    // Downstream stub: one-clock pixel return, garbage when not requested
    always @(posedge clk) pd <= req ? {y[7:0], x, 5'd0} : 24'hA5A5A5;
    typedef struct {
        int          k;
        logic        req;
        logic [10:0] x, y;
        logic        hs, vs, de;
        logic [23:0] rgb;
    } vec_t;
    vec_t tbl[20];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic adv_to(input int k);
        while (cyc < k) begin
            @(negedge clk);
            cyc++;
        end
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [10:0] ex, ey;
        int n_hs, n_vs, n_de;
        tbl[0]  = '{0,   1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 24'h0};
        tbl[1]  = '{1,   1'b0, 11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 24'h0};
        tbl[2]  = '{4,   1'b0, 11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 24'h0};
        tbl[3]  = '{5,   1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b0, 24'h0};
        tbl[4]  = '{46,  1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b0, 24'h0};
        tbl[5]  = '{47,  1'b0, 11'd0, 11'd0, 1'b1, 1'b0, 1'b0, 24'h0};
        tbl[6]  = '{124, 1'b1, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 24'h0};
        tbl[7]  = '{125, 1'b1, 11'd1, 11'd0, 1'b0, 1'b0, 1'b0, 24'h0};
        tbl[8]  = '{126, 1'b1, 11'd2, 11'd0, 1'b0, 1'b0, 1'b1, 24'h0};
        tbl[9]  = '{127, 1'b1, 11'd3, 11'd0, 1'b0, 1'b0, 1'b1, 24'h000020};
        tbl[10] = '{133, 1'b1, 11'd9, 11'd0, 1'b0, 1'b0, 1'b1, 24'h0000E0};
        tbl[11] = '{134, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 24'h000100};
        tbl[12] = '{135, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 24'h000120};
        tbl[13] = '{136, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 24'h0};
        tbl[14] = '{202, 1'b1, 11'd9, 11'd3, 1'b0, 1'b0, 1'b1, 24'h0300E0};
        tbl[15] = '{204, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 24'h030120};
        tbl[16] = '{216, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 24'h0};
        tbl[17] = '{253, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 24'h0};
        tbl[18] = '{254, 1'b0, 11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 24'h0};
        tbl[19] = '{377, 1'b1, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 24'h0};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            adv_to(tbl[i].k);
            chk($sformatf("vec%0d k=%0d {req,x,y,hs,vs,de,rgb}", i, tbl[i].k),
                {req, x, y, hs, vs, de, rgb},
                {tbl[i].req, tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs, tbl[i].de, tbl[i].rgb});
        end
        // Asynchronous reset mid-line inside the active area
        adv_to(429);
        chk("pre_reset_de", de, 1);
        #2 rst = 1'b1;
        #1 chk("async_reset {de,rgb,hs,vs,req,x,y}", {de, rgb, hs, vs, req, x, y}, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        while (!req && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("first_req_after_reset", cyc, 124);
        // Two full frames: stream order, blanking and sync widths
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ex = 0; ey = 0; n_hs = 0; n_vs = 0; n_de = 0;
        for (int k = 1; k <= 506; k++) begin
            @(negedge clk);
            n_hs += int'(hs);
            n_vs += int'(vs);
            n_de += int'(de);
            if (de) begin
                chk($sformatf("stream k=%0d", k), rgb, {ey[7:0], ex, 5'd0});
                ex = ex + 11'd1;
                if (ex == 11'd10) begin
                    ex = 0;
                    ey = (ey == 11'd3) ? 11'd0 : ey + 11'd1;
                end
            end else
                chk($sformatf("blank_rgb k=%0d", k), rgb, 0);
        end
        chk("hs_high_clocks_2frames", n_hs, 88);
        chk("vs_high_clocks_2frames", n_vs, 92);
        chk("de_clocks_2frames", n_de, 80);
        chk("stream_ends_on_frame", {ex, ey}, 0);
        // Default 1280x720 timing
        chk("def_reset {de,rgb,hs,vs,req,x,y}", {de_d, rgb_d, hs_d, vs_d, req_d, x_d, y_d}, 0);
        rst_d = 1'b0;
        cyc = 0;
        adv_to(1);     chk("def_hs_first_edge", hs_d, 1);
        adv_to(40);    chk("def_hs_k40", hs_d, 1);
        adv_to(41);    chk("def_hs_k41", hs_d, 0);
        adv_to(1650);  chk("def_hs_k1650", hs_d, 0);
        adv_to(1651);  chk("def_hs_period", hs_d, 1);
        adv_to(8250);  chk("def_vs_last", vs_d, 1);
        adv_to(8251);  chk("def_vs_end", vs_d, 0);
        adv_to(41508); chk("def_req_before", req_d, 0);
        adv_to(41509); chk("def_first_req {req,x,y}", {req_d, x_d, y_d}, {1'b1, 11'd0, 11'd0});
        adv_to(41510); chk("def_de_before", de_d, 0);
        adv_to(41511); chk("def_de_start", de_d, 1);
        adv_to(42788); chk("def_last_req {req,x,y}", {req_d, x_d, y_d}, {1'b1, 11'd1279, 11'd0});
        adv_to(42789); chk("def_req_end {req,x,y}", {req_d, x_d, y_d}, 0);
        adv_to(42790); chk("def_de_last", de_d, 1);
        adv_to(42791); chk("def_de_end", {de_d, rgb_d}, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
